// File: rtl/lsu_mem_stage.sv
// Single-outstanding load/store stage between execute and the data-cache port.
// Builds byte enables and replicated store data, aligns loads and bounds the cache wait.
module lsu_mem_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_err,
   output logic                busy
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   localparam logic [1:0] ErrOk    = 2'b00;
   localparam logic [1:0] ErrAlign = 2'b01;
   localparam logic [1:0] ErrTmo   = 2'b10;
   localparam logic [1:0] ErrSize  = 2'b11;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              uns_q, uns_d;
   logic [1:0]        size_q, size_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;

   function automatic logic misaligned(input logic [2:0] a, input logic [1:0] size);
      case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = a[0];
         2'd2:    misaligned = |a[1:0];
         default: misaligned = |a[2:0];
      endcase
   endfunction

   function automatic logic [NB-1:0] calc_be(input logic [1:0] size, input logic [OFF_W-1:0] off);
      int nb;
      int o;
      nb = 1 << size;
      o  = int'(off);
      for (int i = 0; i < int'(NB); i++) begin
         calc_be[i] = (i >= o) && (i < o + nb);
      end
   endfunction

   function automatic logic [DATA_W-1:0] rep_data(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
      int nb;
      nb = 1 << size;
      for (int i = 0; i < int'(NB); i++) begin
         rep_data[8*i +: 8] = d[8*(i % nb) +: 8];
      end
   endfunction

   function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] rdata,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
      logic [DATA_W-1:0] sh;
      logic              sgn;
      int                nbits;
      sh    = rdata >> {off, 3'b000};
      nbits = 8 << size;
      if (nbits > int'(DATA_W)) nbits = int'(DATA_W);
      sgn = ~uns & sh[nbits-1];
      for (int i = 0; i < int'(DATA_W); i++) begin
         align_load[i] = (i < nbits) ? sh[i] : sgn;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      uns_d       = uns_q;
      size_d      = size_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               uns_d  = req_unsigned;
               size_d = req_size;
               off_d  = req_addr[OFF_W-1:0];
               if ((req_size == 2'd3) && (DATA_W == 32)) begin
                  state_d     = StResp;
                  rsp_err_d   = ErrSize;
                  rsp_rdata_d = '0;
               end else if (misaligned(req_addr[2:0], req_size)) begin
                  state_d     = StResp;
                  rsp_err_d   = ErrAlign;
                  rsp_rdata_d = '0;
               end else begin
                  state_d     = StReq;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = req_addr & ~ADDR_W'(NB - 1);
                  mem_wdata_d = rep_data(req_wdata, req_size);
                  mem_be_d    = calc_be(req_size, req_addr[OFF_W-1:0]);
               end
            end
         end
         StReq, StWait: begin
            // An ack on the final permitted cycle wins over the timeout.
            if (mem_ack) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               rsp_err_d   = ErrOk;
               rsp_rdata_d = mem_we_q ? '0 : align_load(mem_rdata, off_q, size_q, uns_q);
            end else if (state_q == StReq) begin
               state_d = StWait;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               rsp_err_d   = ErrTmo;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (rsp_ready) state_d = StIdle;
         end
      endcase

      rsp_valid_d = (state_d == StResp);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         uns_q       <= 1'b0;
         size_q      <= 2'd0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 2'b00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         uns_q       <= uns_d;
         size_q      <= size_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = rst_n && (state_q == StIdle);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: 32- and 64-bit instances driven by directed and random
// transactions, checked against an arithmetic reference model.
module tb_lsu_mem_stage;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid32, req_valid64, req_we, req_unsigned, mem_ack, rsp_ready;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, mem_rdata;
   logic [1:0]  req_size;
   logic        sel;

   logic        rr32, mreq32, mwe32, rv32, busy32;
   logic [31:0] maddr32, mwd32, rd32;
   logic [3:0]  mbe32;
   logic [1:0]  err32;
   logic        rr64, mreq64, mwe64, rv64, busy64;
   logic [31:0] maddr64;
   logic [63:0] mwd64, rd64;
   logic [7:0]  mbe64;
   logic [1:0]  err64;

   lsu_mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid32), .req_ready(rr32), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_size(req_size),
      .req_unsigned(req_unsigned), .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32),
      .mem_wdata(mwd32), .mem_be(mbe32), .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0]),
      .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_rdata(rd32), .rsp_err(err32),
      .busy(busy32)
   );

   lsu_mem_stage #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid64), .req_ready(rr64), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned), .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64),
      .mem_wdata(mwd64), .mem_be(mbe64), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rv64), .rsp_ready(rsp_ready), .rsp_rdata(rd64), .rsp_err(err64),
      .busy(busy64)
   );

   logic        o_rr, o_mreq, o_mwe, o_rv, o_busy;
   logic [31:0] o_maddr;
   logic [63:0] o_mwd, o_rd;
   logic [7:0]  o_mbe;
   logic [1:0]  o_err;

   assign o_rr    = sel ? rr64 : rr32;
   assign o_mreq  = sel ? mreq64 : mreq32;
   assign o_mwe   = sel ? mwe64 : mwe32;
   assign o_rv    = sel ? rv64 : rv32;
   assign o_busy  = sel ? busy64 : busy32;
   assign o_maddr = sel ? maddr64 : maddr32;
   assign o_mwd   = sel ? mwd64 : {32'd0, mwd32};
   assign o_rd    = sel ? rd64 : {32'd0, rd32};
   assign o_mbe   = sel ? mbe64 : {4'd0, mbe32};
   assign o_err   = sel ? err64 : err32;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: expected results from the size/offset rules with wide plain arithmetic.
   function automatic void model(input bit w64, input bit we, input logic [31:0] addr,
                                 input logic [1:0] size, input bit uns,
                                 input logic [63:0] wd, input logic [63:0] rd,
                                 output logic [1:0] err, output logic [7:0] be,
                                 output logic [63:0] wdo, output logic [63:0] rdo,
                                 output logic [31:0] maddr);
      int nbw, nbytes, off;
      logic [127:0] lm, acc, lane, rdw;
      nbw    = w64 ? 8 : 4;
      nbytes = 1 << size;
      off    = int'(addr % nbw);
      if (size == 2'd3 && !w64)        err = 2'b11;
      else if (addr % nbytes != 0)     err = 2'b01;
      else                             err = 2'b00;
      maddr = addr - 32'(off);
      be    = 8'(((1 << nbytes) - 1) << off);
      lm    = (128'd1 << (8 * nbytes)) - 128'd1;
      acc   = '0;
      for (int k = 0; k * nbytes < nbw; k++) acc = acc | ((128'(wd) & lm) << (8 * nbytes * k));
      wdo  = acc[63:0];
      rdw  = w64 ? 128'(rd) : 128'(rd[31:0]);
      lane = (rdw >> (8 * off)) & lm;
      if (!uns && lane >= (128'd1 << (8 * nbytes - 1))) lane = lane - (128'd1 << (8 * nbytes));
      rdo = lane[63:0];
      if (!w64) rdo[63:32] = 32'd0;
      if (we || err != 2'b00) rdo = '0;
   endfunction

   // ack_at: cycle index (0 = first mem_req cycle) at which to ack; negative = never.
   task automatic do_txn(input bit s, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [63:0] wd,
                         input logic [63:0] rd, input int ack_at, input int hold);
      logic [1:0]  err;
      logic [7:0]  be;
      logic [63:0] wdo, rdo;
      logic [31:0] maddr;
      int          n;
      model(s, we, addr, size, uns, wd, rd, err, be, wdo, rdo, maddr);
      sel = s;
      @(negedge clk);
      chk("req_ready_idle", 64'(o_rr), 64'd1);
      req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
      if (s) req_valid64 = 1'b1; else req_valid32 = 1'b1;
      @(negedge clk);
      req_valid32 = 1'b0; req_valid64 = 1'b0;
      req_wdata = {$urandom, $urandom};
      if (err != 2'b00) begin
         chk("no_mem_req", 64'(o_mreq), 64'd0);
      end else begin
         chk("mem_req", 64'(o_mreq), 64'd1);
         chk("mem_we", 64'(o_mwe), 64'(we));
         chk("mem_addr", 64'(o_maddr), 64'(maddr));
         chk("mem_be", 64'(o_mbe), 64'(be));
         if (we) chk("mem_wdata", o_mwd, wdo);
         chk("req_ready_busy", 64'(o_rr), 64'd0);
         n = 0;
         while (o_mreq && n < 40) begin
            if (n == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
            n++;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = {$urandom, $urandom};
         end
         if (ack_at < 0) begin
            err = 2'b10;
            rdo = '0;
            chk("req_cycles", 64'(n), 64'(TO + 1));
         end else begin
            chk("req_cycles", 64'(n), 64'(ack_at + 1));
         end
      end
      chk("rsp_valid", 64'(o_rv), 64'd1);
      chk("rsp_err", 64'(o_err), 64'(err));
      chk("rsp_rdata", o_rd, rdo);
      for (int h = 0; h < hold; h++) begin
         if (ack_at < 0 && h == 0) begin mem_ack = 1'b1; mem_rdata = {$urandom, $urandom}; end
         @(negedge clk);
         mem_ack = 1'b0;
         chk("hold_valid", 64'(o_rv), 64'd1);
         chk("hold_rdata", o_rd, rdo);
         chk("hold_err", 64'(o_err), 64'(err));
         chk("hold_ready", 64'(o_rr), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", 64'(o_rv), 64'd0);
      chk("ready_after", 64'(o_rr), 64'd1);
      chk("busy_after", 64'(o_busy), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          ack;
      sel = 1'b0;
      req_valid32 = 1'b0; req_valid64 = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
      mem_ack = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
      req_size = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 64'({mreq32, mreq64}), 64'd0);
      chk("rst_rsp_valid", 64'({rv32, rv64}), 64'd0);
      chk("rst_busy", 64'({busy32, busy64}), 64'd0);
      chk("rst_mem_we", 64'({mwe32, mwe64}), 64'd0);
      chk("rst_mem_addr", {maddr32, maddr64}, 64'd0);
      chk("rst_mem_wdata", mwd64 | 64'(mwd32), 64'd0);
      chk("rst_mem_be", 64'({mbe32, mbe64}), 64'd0);
      chk("rst_rsp_rdata", rd64 | 64'(rd32), 64'd0);
      chk("rst_rsp_err", 64'({err32, err64}), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 64'({rr32, rr64}), 64'd3);

      // Directed cases
      do_txn(1'b0, 1'b0, 32'h1003, 2'd0, 1'b0, 64'd0, 64'h80FF_FF12, 1, 0);
      do_txn(1'b0, 1'b1, 32'h2002, 2'd1, 1'b0, 64'h0000_BEEF, 64'h1234_5678, 0, 0);
      do_txn(1'b0, 1'b0, 32'h3001, 2'd2, 1'b0, 64'd0, 64'hDEAD_BEEF, 0, 1);
      do_txn(1'b0, 1'b0, 32'h4000, 2'd3, 1'b0, 64'd0, 64'hDEAD_BEEF, 0, 0);
      do_txn(1'b0, 1'b0, 32'h5000, 2'd2, 1'b1, 64'd0, 64'h1111_2222, -1, 2);
      do_txn(1'b0, 1'b0, 32'h5004, 2'd2, 1'b0, 64'd0, 64'hCAFE_F00D, 2, 0);
      do_txn(1'b0, 1'b0, 32'h6006, 2'd1, 1'b0, 64'd0, 64'h9ABC_0000, TO, 6);
      do_txn(1'b1, 1'b1, 32'h7005, 2'd0, 1'b0, 64'hA5, 64'd0, 3, 0);
      do_txn(1'b1, 1'b0, 32'h7004, 2'd2, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 1, 0);

      // Asynchronous reset while waiting on the cache
      sel = 1'b0;
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
      req_valid32 = 1'b1;
      @(negedge clk);
      req_valid32 = 1'b0;
      chk("wait_mem_req", 64'(mreq32), 64'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_mem_req", 64'(mreq32), 64'd0);
      chk("async_busy", 64'(busy32), 64'd0);
      chk("async_rsp_valid", 64'(rv32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 64'(rr32), 64'd1);
      do_txn(1'b1, 1'b0, 32'h8, 2'd3, 1'b0, 64'd0, {$urandom, $urandom}, 1, 0);

      // Random transactions
      for (int t = 0; t < 80; t++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         ack = int'($urandom_range(0, TO + 1));
         if (ack == int'(TO + 1)) ack = -1;
         do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
                1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                ack, int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
